// File: rtl/csa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : csa_pkg                                                  |
// | Purpose   : Shared types and constants for the byte-serial           |
// |             carry-select adder sequencer.                            |
// |             - state_e   : sequencer FSM states                       |
// |             - BYTE_W    : width of one adder slice                   |
// |             - idx_width : byte-index register width for NBYTES       |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package csa_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-byte operand still needs a 1-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa8_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : csa8_core                                                |
// | Purpose   : Combinational 8-bit carry-select adder.                  |
// |             Low nibble ripples; high nibble is precomputed for both  |
// |             carry values and selected by the low-nibble carry.       |
// | Ports     : a_i[7:0], b_i[7:0], cin_i  -> sum_o[7:0], cout_o         |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module csa8_core (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;
    logic [4:0] w_hi;

    always_comb begin
        w_lo   = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
        w_hi0  = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
        w_hi1  = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;
        w_hi   = w_lo[4] ? w_hi1 : w_hi0;
        sum_o  = {w_hi[3:0], w_lo[3:0]};
        cout_o = w_hi[4];
    end

endmodule
`default_nettype wire

// File: rtl/csa8_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : csa8_add_sequencer                                       |
// | Purpose   : Byte-serial W-bit adder (W = 8*NBYTES). Accepts one      |
// |             request in IDLE, adds one byte per clock LSB first with  |
// |             the carry chained through a register, then holds the     |
// |             result until the consumer takes it.                      |
// | Ports     : clk, rst (sync, active high)                             |
// |             in_valid/in_ready, in_a[W], in_b[W], in_cin, [in_sub]    |
// |             out_valid/out_ready, out_sum[W], out_cout, out_ovf       |
// | Options   : CSA_SEQ_SUB_EN - adds in_sub; when set, computes A-B     |
// |             (B inverted, carry-in forced to 1).                      |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module csa8_add_sequencer
    import csa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                   in_cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = idx_width(NBYTES);
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NBYTES - 1);

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              valid_q;

    // Operand B and carry-in as they are to be latched at accept time.
    logic [W-1:0]      b_acc_d;
    logic              cin_acc_d;

    logic [7:0]        core_a;
    logic [7:0]        core_b;
    logic [7:0]        core_sum;
    logic              core_cout;
    logic              last_byte;

    always_comb begin
`ifdef CSA_SEQ_SUB_EN
        b_acc_d   = in_sub ? ~in_b : in_b;
        cin_acc_d = in_sub ? 1'b1  : in_cin;
`else
        b_acc_d   = in_b;
        cin_acc_d = in_cin;
`endif
    end

    always_comb begin
        core_a    = a_q[BYTE_W*idx_q +: BYTE_W];
        core_b    = b_q[BYTE_W*idx_q +: BYTE_W];
        last_byte = (idx_q == C_LAST_IDX);
    end

    csa8_core u_core (
        .a_i    (core_a),
        .b_i    (core_b),
        .cin_i  (carry_q),
        .sum_o  (core_sum),
        .cout_o (core_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_acc_d;
                        carry_q <= cin_acc_d;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[BYTE_W*idx_q +: BYTE_W] <= core_sum;
                    carry_q <= core_cout;
                    if (last_byte) begin
                        idx_q   <= '0;
                        cout_q  <= core_cout;
                        // Signed overflow uses the effective (possibly inverted) B.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (core_sum[7] != a_q[W-1]);
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csa8_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_csa8_add_sequencer                                    |
// | Purpose   : Directed, table-driven bench for csa8_add_sequencer      |
// |             with NBYTES=4. Subtract vectors run when CSA_SEQ_SUB_EN  |
// |             is defined.                                              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_csa8_add_sequencer;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
`ifdef CSA_SEQ_SUB_EN
    logic        in_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    csa8_add_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CSA_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present v for one edge, then scramble the inputs so the DUT must have latched them.
    task automatic accept(input vec_t v, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
`ifdef CSA_SEQ_SUB_EN
        in_sub   = v.sub;
`endif
        chk({nm, " in_ready before accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom);
`ifdef CSA_SEQ_SUB_EN
        in_sub   = 1'($urandom);
`endif
    endtask

    // Called #1 after the accept edge; counts edges until out_valid rises.
    task automatic wait_valid(input string nm);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(NB));
    endtask

    task automatic release_result(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " out_valid after release"}, 64'(out_valid), 64'd0);
        chk({nm, " in_ready after release"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        accept(v, nm);
        wait_valid(nm);
        chk({nm, " sum"},  64'(out_sum),  64'(v.sum));
        chk({nm, " cout"}, 64'(out_cout), 64'(v.cout));
        chk({nm, " ovf"},  64'(out_ovf),  64'(v.ovf));
        release_result(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           a             b             cin   sub   sum           cout  ovf
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_sum",   64'(out_sum),   64'd0);
        chk("reset out_cout",  64'(out_cout),  64'd0);
        chk("reset out_ovf",   64'(out_ovf),   64'd0);

        // Table of additions
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Result held under back-pressure with a second request pending
        accept(vecs[3], "hold");
        wait_valid("hold");
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'hFFFFFFFF;
        in_b     = 32'h00000001;
        in_cin   = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        in_sub   = 1'b0;
`endif
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d out_sum", k),   64'(out_sum),   64'h2345678A);
            chk($sformatf("hold%0d in_ready", k),  64'(in_ready),  64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold release out_valid", 64'(out_valid), 64'd0);
        chk("hold release in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("second accepted in_ready", 64'(in_ready), 64'd0);
        wait_valid("second");
        chk("second sum",  64'(out_sum),  64'h00000000);
        chk("second cout", 64'(out_cout), 64'd1);
        release_result("second");

        // Abort after two RUN cycles
        accept(vecs[1], "abort");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort in_ready",  64'(in_ready),  64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_sum",   64'(out_sum),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], "after_abort");

`ifdef CSA_SEQ_SUB_EN
        begin
            vec_t s0;
            vec_t s1;
            s0 = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
            s1 = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
            run_vec(s0, "sub0");
            run_vec(s1, "sub1");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
